// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder:
// the lookahead group width and the group propagate/generate helper.
package cla_pkg;

  localparam int GROUP_W = 4;

  // Collapse per-bit propagate/generate of one group into {P, G}.
  function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] p,
                                          input logic [GROUP_W-1:0] g);
    logic gp;
    logic gg;
    gp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gp, gg};
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: local sum from a supplied carry-in, plus the
// group propagate/generate used by the enclosing lookahead unit.
// P/G depend only on the operands so the outer lookahead has no loop through ci.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               p,
  output logic               g
);

  logic [GROUP_W-1:0] pb;
  logic [GROUP_W-1:0] gb;
  logic [GROUP_W-1:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  // Group propagate/generate, independent of the carry-in.
  always_comb begin
    {p, g} = group_pg(pb, gb);
  end

  // Bit carries inside the group, fully expanded, then the sum bits.
  always_comb begin
    c[0] = ci;
    c[1] = gb[0] | (pb[0] & ci);
    c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & ci);
    s    = pb ^ c;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each of STAGES stages resolves WIDTH/(4*STAGES) lookahead groups; the carry
// between slices is registered. WIDTH must be a multiple of 4 and STAGES must
// divide WIDTH/4.
// Optional build macro CLA_PIPE_SAT_EN: saturate the sum to the signed
// max/min on overflow (applied in the last stage, latency unchanged).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GROUP_W;
  localparam int GPS  = NGRP / STAGES;
  localparam int SW   = GPS * GROUP_W;

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;

`ifdef CLA_PIPE_SAT_EN
  // On overflow the wrapped MSB is the inverse of the true sign, so an MSB of 1
  // means the true result was too large positive.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s,
                                               input logic             of);
    if (!of) return s;
    return s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
`endif

  // A stage may move when some stage below it is empty or the consumer takes
  // the last beat; computed from the output side so bubbles collapse.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      adv[k] = vld_p[k] & room;
      room   = room | ~vld_p[k];
    end
  end

  assign in_ready = ~vld_p[0] | adv[0];

  // Stage load enables: stage 0 from the input port, others from the stage above.
  always_comb begin
    ld    = '0;
    ld[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) ld[k] = adv[k-1];
  end

  // Stage occupancy; reset discards every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= ld | (vld_p & ~adv);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RIN = WIDTH - k*SW;

    logic [RIN-1:0]        a_in;
    logic [RIN-1:0]        b_in;
    logic                  c_in;
    logic [SW-1:0]         s_grp;
    logic [GPS-1:0]        gp;
    logic [GPS-1:0]        gg;
    logic [GPS:0]          gc;
    logic [(k+1)*SW-1:0]   s_nx;

    if (k == 0) begin : g_src
      // Subtraction is a + ~b + 1; cin is ignored in that case.
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub | cin;
      assign s_nx = s_grp;
    end else begin : g_src
      assign a_in = g_stg[k-1].g_mid.a_q;
      assign b_in = g_stg[k-1].g_mid.b_q;
      assign c_in = g_stg[k-1].g_mid.c_q;
      assign s_nx = {s_grp, g_stg[k-1].g_mid.s_q};
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group4 u_grp (
        .a  (a_in[j*GROUP_W +: GROUP_W]),
        .b  (b_in[j*GROUP_W +: GROUP_W]),
        .ci (gc[j]),
        .s  (s_grp[j*GROUP_W +: GROUP_W]),
        .p  (gp[j]),
        .g  (gg[j])
      );
    end

    // Group carries as independent sum-of-products over group P/G.
    always_comb begin
      logic term;
      gc = '0;
      for (int j = 0; j <= GPS; j++) begin
        term = c_in;
        for (int i = 0; i < j; i++) term = term & gp[i];
        gc[j] = term;
        for (int i = 0; i < j; i++) begin
          term = gg[i];
          for (int m = i + 1; m < j; m++) term = term & gp[m];
          gc[j] = gc[j] | term;
        end
      end
    end

    if (k < STAGES-1) begin : g_mid
      logic [RIN-SW-1:0]   a_q;
      logic [RIN-SW-1:0]   b_q;
      logic [(k+1)*SW-1:0] s_q;
      logic                c_q;

      // Stage boundary: keep finished low sum, forward unresolved upper operands.
      always_ff @(posedge clk) begin
        if (ld[k]) begin
          a_q <= a_in[RIN-1:SW];
          b_q <= b_in[RIN-1:SW];
          s_q <= s_nx;
          c_q <= gc[GPS];
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             o_q;
      logic             ovf_nx;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      assign ovf_nx = gc[GPS] ^ (a_in[RIN-1] ^ b_in[RIN-1] ^ s_nx[WIDTH-1]);

      // Output boundary: final sum, carry out and overflow of this beat.
      always_ff @(posedge clk) begin
        if (ld[k]) begin
`ifdef CLA_PIPE_SAT_EN
          s_q <= sat_sum(s_nx, ovf_nx);
`else
          s_q <= s_nx;
`endif
          c_q <= gc[GPS];
          o_q <= ovf_nx;
        end
      end
    end
  end

  // Result fields read as zero whenever no beat is presented.
  assign out_valid = vld_p[STAGES-1];
  assign sum       = out_valid ? g_stg[STAGES-1].g_last.s_q : '0;
  assign cout      = out_valid & g_stg[STAGES-1].g_last.c_q;
  assign ovf       = out_valid & g_stg[STAGES-1].g_last.o_q;

endmodule
